// File: rtl/reg_file_param.sv
// reg_file_param
//   Parametrised general-purpose register file with two combinational read
//   ports, one synchronous write port, an optional hardwired-zero entry 0,
//   optional write-to-read bypass and a sequential clear sweep that zeroes
//   one entry per clock after a CLEAR request.
//
// Parameters
//   DATA_W    register width in bits
//   ADDR_W    address width, DEPTH = 2**ADDR_W entries
//   ZERO_REG  1: entry 0 always reads 0 and ignores writes
//   BYPASS    1: an accepted write is forwarded to a read port addressing it
//
// Ports
//   CLK          clock, all state updates on the rising edge
//   RESET        synchronous active-high reset, zeroes every entry
//   WRITE        write enable
//   INADDRESS    write address
//   INDATA       write data
//   OUT1ADDRESS  read port 1 address
//   OUT2ADDRESS  read port 2 address
//   CLEAR        request a sequential clear of all entries
//   OUT1DATA     read port 1 data (combinational)
//   OUT2DATA     read port 2 data (combinational)
//   BUSY         clear sweep in progress, writes are dropped
module reg_file_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic [DATA_W-1:0] INDATA,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  input  logic              CLEAR,
  output logic [DATA_W-1:0] OUT1DATA,
  output logic [DATA_W-1:0] OUT2DATA,
  output logic              BUSY
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;
  logic [DATA_W-1:0] entry_reg [DEPTH];

  logic sweeping;
  logic zero_target;
  logic acc;

  assign sweeping    = (state_reg == SWEEP);
  assign BUSY        = sweeping;
  assign zero_target = (ZERO_REG != 0) && (INADDRESS == '0);
  assign acc         = WRITE && !RESET && !sweeping && !zero_target;

  // Sweep controller
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (CLEAR) begin
          state_next = SWEEP;
          ptr_next   = '0;
        end
      end
      SWEEP: begin
        // The pointer is exactly ADDR_W bits, so the terminal entry is all
        // ones and the increment wraps back to 0 on its own.
        ptr_next = ptr_reg + 1'b1;
        if (ptr_reg == {ADDR_W{1'b1}}) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        ptr_next   = '0;
      end
    endcase
  end

  // Storage: one register per entry so reset can clear the whole array at once
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge CLK) begin
        if (RESET) begin
          entry_reg[gi] <= '0;
        end else if (sweeping && (ptr_reg == ADDR_W'(gi))) begin
          entry_reg[gi] <= '0;
        end else if (acc && (INADDRESS == ADDR_W'(gi))) begin
          entry_reg[gi] <= INDATA;
        end
      end
    end
  endgenerate

  // Read ports
  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];

  assign rd_addr[0] = OUT1ADDRESS;
  assign rd_addr[1] = OUT2ADDRESS;
  assign OUT1DATA   = rd_data[0];
  assign OUT2DATA   = rd_data[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_read
      always_comb begin
        rd_data[gi] = entry_reg[rd_addr[gi]];
        // acc is never true for entry 0 under ZERO_REG, so the zero check
        // takes priority over forwarding without conflict.
        if ((ZERO_REG != 0) && (rd_addr[gi] == '0)) begin
          rd_data[gi] = '0;
        end else if ((BYPASS != 0) && acc && (rd_addr[gi] == INADDRESS)) begin
          rd_data[gi] = INDATA;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_param.sv
// Testbench for reg_file_param: three instances (8x8 plain, 8x8 with zero
// register and bypass, 32x32 with bypass) share one stimulus stream. The
// driver pushes the expected read/busy values from a reference model into a
// queue; a monitor pops and compares on every falling edge.
module tb_reg_file_param;

  logic        clk;
  logic        rst;
  logic        wr;
  logic        clr;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic [4:0]  a1;
  logic [4:0]  a2;

  logic [7:0]  d0_o1, d0_o2, d1_o1, d1_o2;
  logic [31:0] d2_o1, d2_o2;
  logic [2:0]  busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  reg_file_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) dut0 (
    .CLK(clk), .RESET(rst), .WRITE(wr), .INADDRESS(in_addr[2:0]),
    .INDATA(in_data[7:0]), .OUT1ADDRESS(a1[2:0]), .OUT2ADDRESS(a2[2:0]),
    .CLEAR(clr), .OUT1DATA(d0_o1), .OUT2DATA(d0_o2), .BUSY(busy[0]));

  reg_file_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dut1 (
    .CLK(clk), .RESET(rst), .WRITE(wr), .INADDRESS(in_addr[2:0]),
    .INDATA(in_data[7:0]), .OUT1ADDRESS(a1[2:0]), .OUT2ADDRESS(a2[2:0]),
    .CLEAR(clr), .OUT1DATA(d1_o1), .OUT2DATA(d1_o2), .BUSY(busy[1]));

  reg_file_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(1)) dut2 (
    .CLK(clk), .RESET(rst), .WRITE(wr), .INADDRESS(in_addr),
    .INDATA(in_data), .OUT1ADDRESS(a1), .OUT2ADDRESS(a2),
    .CLEAR(clr), .OUT1DATA(d2_o1), .OUT2DATA(d2_o2), .BUSY(busy[2]));

  // Per-instance configuration
  function automatic int dep(input int c);
    return (c == 2) ? 32 : 8;
  endfunction
  function automatic longint unsigned dmask(input int c);
    return (c == 2) ? 64'hFFFF_FFFF : 64'hFF;
  endfunction
  function automatic bit zr(input int c);
    return c == 1;
  endfunction
  function automatic bit bp(input int c);
    return c != 0;
  endfunction

  typedef struct packed {
    logic [2:0][31:0] o1;
    logic [2:0][31:0] o2;
    logic [2:0]       bsy;
    logic [4:0]       ra1;
    logic [4:0]       ra2;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: register contents and remaining clear work per instance
  int unsigned mem [3][32];
  bit          m_busy [3];
  int          m_next [3];

  int total = 0;
  int bad   = 0;

  function automatic int unsigned model_read(input int c, input int a,
                                             input bit acc, input int wa,
                                             input int unsigned wd);
    if (zr(c) && a == 0) return 0;
    if (bp(c) && acc && a == wa) return wd;
    return mem[c][a];
  endfunction

  // One clock of stimulus: drive inputs, push expectations, advance the model
  task automatic cycle(input bit r, input bit w, input int ia,
                       input int unsigned d, input int ra1, input int ra2,
                       input bit c_in);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; wr = w; clr = c_in;
    in_addr = 5'(ia); in_data = d; a1 = 5'(ra1); a2 = 5'(ra2);
    e = '0;
    e.ra1 = 5'(ra1);
    e.ra2 = 5'(ra2);
    for (int c = 0; c < 3; c++) begin
      int          wa;
      int unsigned wd;
      bit          acc;
      wa  = ia % dep(c);
      wd  = 32'(longint'(d) & dmask(c));
      acc = w && !r && !m_busy[c] && !(zr(c) && wa == 0);
      e.o1[c]  = model_read(c, ra1 % dep(c), acc, wa, wd);
      e.o2[c]  = model_read(c, ra2 % dep(c), acc, wa, wd);
      e.bsy[c] = m_busy[c];
      // Contents before the first reset are unknown, so nothing is checked
      // during a reset cycle; everything after it is.
      if (r) begin
        for (int k = 0; k < 32; k++) mem[c][k] = 0;
        m_busy[c] = 0;
        m_next[c] = 0;
      end else if (m_busy[c]) begin
        mem[c][m_next[c]] = 0;
        m_next[c]++;
        if (m_next[c] == dep(c)) m_busy[c] = 0;
      end else begin
        if (acc) mem[c][wa] = wd;
        if (c_in) begin
          m_busy[c] = 1;
          m_next[c] = 0;
        end
      end
    end
    if (!r) exp_q.push_back(e);
  endtask

  task automatic idle(input int ra1, input int ra2);
    cycle(0, 0, 0, 0, ra1, ra2, 0);
  endtask

  // Monitor: compare every presented output against the oldest expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [2:0][31:0] g1, g2;
      e = exp_q.pop_front();
      g1[0] = {24'd0, d0_o1}; g1[1] = {24'd0, d1_o1}; g1[2] = d2_o1;
      g2[0] = {24'd0, d0_o2}; g2[1] = {24'd0, d1_o2}; g2[2] = d2_o2;
      for (int c = 0; c < 3; c++) begin
        total++;
        if (g1[c] !== e.o1[c]) begin
          bad++;
          $display("FAIL out1_dut%0d addr=%0d got=%h want=%h t=%0t",
                   c, e.ra1, g1[c], e.o1[c], $time);
        end
        total++;
        if (g2[c] !== e.o2[c]) begin
          bad++;
          $display("FAIL out2_dut%0d addr=%0d got=%h want=%h t=%0t",
                   c, e.ra2, g2[c], e.o2[c], $time);
        end
        total++;
        if (busy[c] !== e.bsy[c]) begin
          bad++;
          $display("FAIL busy_dut%0d got=%b want=%b t=%0t",
                   c, busy[c], e.bsy[c], $time);
        end
      end
      $display("cycle t=%0t a1=%0d a2=%0d o1=%h/%h/%h o2=%h/%h/%h busy=%b",
               $time, e.ra1, e.ra2, g1[0], g1[1], g1[2],
               g2[0], g2[1], g2[2], busy);
    end
  end

  initial begin
    rst = 1'b0; wr = 1'b0; clr = 1'b0;
    in_addr = '0; in_data = '0; a1 = '0; a2 = '0;
    for (int c = 0; c < 3; c++) begin
      m_busy[c] = 0;
      m_next[c] = 0;
      for (int k = 0; k < 32; k++) mem[c][k] = 0;
    end

    // Reset and basic write/read
    cycle(1, 0, 0, 0, 0, 0, 0);
    idle(3, 4);
    cycle(0, 1, 3, 32'h5A, 3, 4, 0);
    idle(3, 4);

    // Bypass: same-cycle forwarding on both ports
    cycle(0, 1, 2, 32'hC3, 2, 2, 0);
    idle(2, 2);

    // Zero register
    cycle(0, 1, 0, 32'hFF, 0, 1, 0);
    idle(0, 1);
    cycle(0, 1, 1, 32'hFF, 0, 1, 0);
    idle(0, 1);

    // Clear sweep with a dropped write in the middle
    for (int i = 0; i < 8; i++) cycle(0, 1, i, 32'h11 * (i + 1), i, 7 - i, 0);
    cycle(0, 0, 0, 0, 0, 3, 1);
    for (int i = 0; i < 9; i++) begin
      if (i == 3) cycle(0, 1, 5, 32'h99, 3, 5, 0);
      else        idle(i % 8, 5);
    end
    for (int i = 0; i < 8; i++) idle(i, 7 - i);

    // Reset mid-sweep, then write after
    for (int i = 0; i < 8; i++) cycle(0, 1, i, 32'hA0 + i, i, i, 0);
    cycle(0, 0, 0, 0, 0, 0, 1);
    idle(0, 1);
    idle(1, 2);
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) idle(i, 7 - i);
    cycle(0, 1, 7, 32'h12, 7, 7, 0);
    idle(7, 7);

    // Wide: write top entry, clear with a CLEAR retriggered mid-sweep
    cycle(0, 1, 31, 32'hDEADBEEF, 31, 30, 0);
    idle(31, 30);
    cycle(0, 0, 0, 0, 31, 0, 1);
    for (int i = 0; i < 34; i++) begin
      if (i == 10) cycle(0, 0, 0, 0, 31, 9, 1);
      else         idle(31, i % 32);
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 31), $urandom, $urandom_range(0, 31),
            $urandom_range(0, 31), $urandom_range(0, 24) == 0);
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    #20;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised general-purpose register file for the processor datapath. Generalises the 8×8 register storage to configurable width and depth. Adds an optional hardwired-zero register, optional write-to-read bypass, and a sequential context-clear engine driven by a software CLEAR request. It sits between the decode stage, which drives the read addresses, and the ALU/writeback path, which drives the write data.

## Interface
- DATA_W, 8, register width in bits (≥1)
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries (ADDR_W ≥1)
- ZERO_REG, 0, 1 = entry 0 always reads 0 and ignores writes
- BYPASS, 0, 1 = same-cycle write data forwarded to matching read port
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high; clock CLK
- WRITE  in  1  write enable
- INADDRESS  in  ADDR_W  write address
- INDATA  in  DATA_W  write data
- OUT1ADDRESS  in  ADDR_W  read port 1 address
- OUT2ADDRESS  in  ADDR_W  read port 2 address
- CLEAR  in  1  request a sequential clear of all entries
- OUT1DATA  out  DATA_W  read port 1 data, combinational
- OUT2DATA  out  DATA_W  read port 2 data, combinational
- BUSY  out  1  clear sweep in progress; writes dropped

## Operation
- Storage: DEPTH × DATA_W array, plus sweep pointer ptr (ADDR_W bits) and FSM state {IDLE, SWEEP}.
- RESET=1 at an edge: all entries ← 0, state ← IDLE, ptr ← 0. RESET overrides WRITE and CLEAR in that cycle.
- Accepted write (acc): WRITE & !RESET & !BUSY & !(ZERO_REG & INADDRESS==0). On the edge, entry[INADDRESS] ← INDATA.
- Reads: OUTnDATA = entry[OUTnADDRESS], combinational.
  - With ZERO_REG=1 and address 0, the read returns 0 regardless of array contents.
  - With BYPASS=1, acc, and OUTnADDRESS==INADDRESS, OUTnDATA = INDATA. This applies to both ports independently.
  - With BYPASS=0, a read returns the old value until the edge.
- FSM:
  - IDLE: CLEAR & !RESET → SWEEP, ptr ← 0. Otherwise stay.
  - SWEEP: each edge, entry[ptr] ← 0 and ptr ← ptr+1. When ptr==DEPTH-1, clear that entry, ptr ← 0, go to IDLE.
  - BUSY = (state==SWEEP).
- CLEAR while BUSY is ignored; it is not queued.
- A WRITE in the same cycle as CLEAR in IDLE is accepted, because BUSY is still 0. The sweep then zeroes that entry.
- A WRITE while BUSY=1 is silently dropped. No error flag.
- Reads during SWEEP return current array contents: entries already swept read 0, entries not yet swept hold their old values. Bypass is inactive because acc=0.
- RESET during SWEEP: array fully zeroed, IDLE, BUSY=0 on the following cycle.
- Pointer wrap: ptr is exactly ADDR_W bits. The terminal compare is against DEPTH-1, so no extra width is needed.

## Timing
- Reset values: all entries 0, BUSY=0, OUT1DATA/OUT2DATA=0 for any address after the reset edge.
- Write latency: data is visible on a non-bypassed read in the cycle after the write edge. With BYPASS=1 it is visible in the same cycle as the write request.
- Clear latency: CLEAR sampled at edge N. BUSY=1 from after edge N through edge N+DEPTH. Entry k is zeroed at edge N+1+k. BUSY=0 after edge N+DEPTH, and writes are accepted at edge N+DEPTH+1.
- No internal sim delays. Outputs settle combinationally within the cycle.

## Test plan
- Reset/basic (DATA_W=8, ADDR_W=3): RESET 1 cycle, write 0x5A to R3, read OUT1ADDRESS=3 next cycle → 0x5A; OUT2ADDRESS=4 → 0x00.
- Bypass (BYPASS=1): WRITE=1, INADDRESS=2, INDATA=0xC3, OUT1ADDRESS=OUT2ADDRESS=2 → both ports 0xC3 in the same cycle. With BYPASS=0 → old value 0x00 in the same cycle, 0xC3 next cycle.
- Zero register (ZERO_REG=1): write 0xFF to R0 → OUT1DATA at address 0 stays 0x00. Write 0xFF to R1 → 0xFF.
- Clear sweep: fill R0..R7 with 0x11..0x88, pulse CLEAR → BUSY high exactly 8 cycles. Mid-sweep after 3 edges, R0–R2 read 0 and R3 reads 0x44. A WRITE of 0x99 to R5 during BUSY is dropped. After BUSY falls, all entries read 0.
- Reset mid-sweep: CLEAR, then RESET after 2 sweep cycles → next cycle BUSY=0, all 8 entries 0. A subsequent write of 0x12 to R7 reads back 0x12.
- Wide config (DATA_W=32, ADDR_W=5): write 0xDEADBEEF to R31 → reads back. CLEAR → BUSY high exactly 32 cycles, R31 then reads 0.
